// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Round-robin arbiter between the AES and SHA control FSMs for the shared
//   8-bit data bus. The winning FSM gets a one-cycle grant pulse. Its command
//   word {address, opcode} is latched during that pulse and then sent out one
//   byte at a time with a valid/ready handshake. The opcode byte goes first,
//   then the address bytes, least significant first.
//
//   Optional build macro: ARB_TIMEOUT_EN
//     When it is defined, a transfer that stalls for TIMEOUT cycles is
//     aborted and err pulses for one cycle. When it is not defined, err is
//     tied to 0 and a stalled transfer waits for bus_ready indefinitely.
//
//   Ports:
//     clk        system clock
//     rst        synchronous active-high reset
//     req_aes    bus request from the AES FSM
//     data_aes   AES command word: [ADDRW+7:8] address, [7:0] opcode
//     grant_aes  one-cycle grant pulse to the AES FSM
//     req_sha    bus request from the SHA FSM
//     data_sha   SHA command word, same layout as data_aes
//     grant_sha  one-cycle grant pulse to the SHA FSM
//     bus_data   byte driven onto the data bus
//     bus_valid  bus_data is valid
//     bus_ready  the bus sink accepts the byte this cycle
//     busy       a transfer is in progress (GRANT or SEND)
//     err        timeout abort pulse (tied to 0 without ARB_TIMEOUT_EN)
module bus_arbiter #(
    parameter int ADDRW     = 24,
    parameter int NREQ_BITS = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_aes,
    input  logic [ADDRW+7:0] data_aes,
    output logic             grant_aes,
    input  logic             req_sha,
    input  logic [ADDRW+7:0] data_sha,
    output logic             grant_sha,
    output logic [7:0]       bus_data,
    output logic             bus_valid,
    input  logic             bus_ready,
    output logic             busy,
    output logic             err
);

    localparam int CMDW   = ADDRW + 8;
    localparam int NBYTES = CMDW / 8;
    localparam int CNTW   = $clog2(NBYTES) + 1;

    localparam logic [CNTW-1:0]      CNT_ONE    = CNTW'(1);
    localparam logic [CNTW-1:0]      CNT_NBYTES = CNTW'(NBYTES);
    localparam logic [NREQ_BITS-1:0] SEL_AES    = NREQ_BITS'(0);
    localparam logic [NREQ_BITS-1:0] SEL_SHA    = NREQ_BITS'(1);

    // The byte serializer needs a whole number of bytes, and the stall limit
    // must be at least one cycle.
    if ((ADDRW % 8) != 0 || TIMEOUT < 1) begin : g_bad_cfg
        $error("bus_arbiter: ADDRW must be a multiple of 8 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [NREQ_BITS-1:0]  winner, winner_nxt;
    logic [NREQ_BITS-1:0]  last_grant;
    logic [CMDW-1:0]       cmd_reg;
    logic [CNTW-1:0]       byte_cnt;
    logic [CNTW-1:0]       len;
    logic [CMDW-1:0]       sel_data;
    logic [CMDW-1:0]       cmd_shifted;
    logic                  accept;
    logic                  last_byte;
    logic                  stall_hit;

    assign sel_data    = (winner == SEL_AES) ? data_aes : data_sha;
    assign accept      = (state == SEND) && bus_ready;
    assign last_byte   = ((byte_cnt + CNT_ONE) == len);
    assign cmd_shifted = cmd_reg >> {byte_cnt, 3'b000};

    assign bus_valid = (state == SEND);
    // Drive zeros when the bus is idle so that bus_data is 0 outside a transfer.
    assign bus_data  = (state == SEND) ? cmd_shifted[7:0] : 8'h00;
    assign busy      = (state != IDLE);

`ifdef ARB_TIMEOUT_EN
    localparam int STW = $clog2(TIMEOUT + 1);

    logic [STW-1:0] stall_cnt;
    logic           err_q;

    // The check is made on the TIMEOUT-th consecutive stall cycle, so the
    // abort takes effect on that edge. err is high in the first IDLE cycle
    // that follows.
    assign stall_hit = (state == SEND) && !bus_ready &&
                       (stall_cnt == STW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= stall_hit;
            if (stall_hit || state != SEND || bus_ready) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + STW'(1);
            end
        end
    end

    assign err = err_q;
`else
    assign stall_hit = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            winner <= SEL_AES;
        end else begin
            state  <= state_nxt;
            winner <= winner_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        winner_nxt = winner;
        grant_aes  = 1'b0;
        grant_sha  = 1'b0;
        case (state)
            IDLE: begin
                if (req_aes && req_sha) begin
                    // On a tie, the requester that was not served last wins.
                    winner_nxt = (last_grant == SEL_AES) ? SEL_SHA : SEL_AES;
                    state_nxt  = GRANT;
                end else if (req_aes) begin
                    winner_nxt = SEL_AES;
                    state_nxt  = GRANT;
                end else if (req_sha) begin
                    winner_nxt = SEL_SHA;
                    state_nxt  = GRANT;
                end
            end
            GRANT: begin
                grant_aes = (winner == SEL_AES);
                grant_sha = (winner == SEL_SHA);
                state_nxt = SEND;
            end
            SEND: begin
                if (accept && last_byte) begin
                    state_nxt = IDLE;
                end else if (stall_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_reg    <= '0;
            byte_cnt   <= '0;
            len        <= '0;
            last_grant <= SEL_SHA;
        end else begin
            case (state)
                GRANT: begin
                    // The requesting FSM holds its word steady while it waits,
                    // so capturing the word during the grant cycle is safe.
                    cmd_reg    <= sel_data;
                    last_grant <= winner;
                    byte_cnt   <= '0;
                    // Opcode low bits 2'b11 mark a hash-op command. It has no
                    // address payload, so only the opcode byte is sent.
                    len        <= (sel_data[1:0] == 2'b11) ? CNT_ONE : CNT_NBYTES;
                end
                SEND: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_aes;
    logic [31:0] data_aes;
    logic        grant_aes;
    logic        req_sha;
    logic [31:0] data_sha;
    logic        grant_sha;
    logic [7:0]  bus_data;
    logic        bus_valid;
    logic        bus_ready;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .ADDRW    (24),
        .NREQ_BITS(1),
        .TIMEOUT  (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_aes  (req_aes),
        .data_aes (data_aes),
        .grant_aes(grant_aes),
        .req_sha  (req_sha),
        .data_sha (data_sha),
        .grant_sha(grant_sha),
        .bus_data (bus_data),
        .bus_valid(bus_valid),
        .bus_ready(bus_ready),
        .busy     (busy),
        .err      (err)
    );

    // Packed layout: {grant_aes, grant_sha, bus_valid, busy, err, bus_data}
    localparam logic [12:0] ERR_BIT = 13'h100;

    typedef struct {
        logic        rst;
        logic        ra;
        logic        rs;
        logic        rdy;
        logic [31:0] da;
        logic [31:0] ds;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [12:0] ex(input logic ga, input logic gs,
                                       input logic v, input logic b,
                                       input logic [7:0] d);
        return {ga, gs, v, b, 1'b0, d};
    endfunction

    function automatic logic [12:0] outs();
        return {grant_aes, grant_sha, bus_valid, busy, err, bus_data};
    endfunction

    function automatic void add(input logic r, input logic ra, input logic rs,
                                input logic rdy, input logic [31:0] da,
                                input logic [31:0] ds, input logic [12:0] e);
        vec_t v;
        v.rst = r; v.ra = ra; v.rs = rs; v.rdy = rdy;
        v.da = da; v.ds = ds; v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [12:0] act,
                         input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got ga=%b gs=%b valid=%b busy=%b err=%b data=%h, expected ga=%b gs=%b valid=%b busy=%b err=%b data=%h",
                     name, act[12], act[11], act[10], act[9], act[8], act[7:0],
                     exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    initial begin
        rst = 1'b1; req_aes = 1'b0; req_sha = 1'b0; bus_ready = 1'b1;
        data_aes = '0; data_sha = '0;

        // AES only: full four-byte word. The request drops during GRANT, but
        // the word is still sent.
        add(1, 0, 0, 1, 32'hABCDEF01, 32'h0, ex(0, 0, 0, 0, 8'h00));
        add(0, 1, 0, 1, 32'hABCDEF01, 32'h0, ex(1, 0, 0, 1, 8'h00));
        add(0, 0, 0, 1, 32'hABCDEF01, 32'h0, ex(0, 0, 1, 1, 8'h01));
        add(0, 0, 0, 1, 32'hABCDEF01, 32'h0, ex(0, 0, 1, 1, 8'hEF));
        add(0, 0, 0, 1, 32'hABCDEF01, 32'h0, ex(0, 0, 1, 1, 8'hCD));
        add(0, 0, 0, 1, 32'hABCDEF01, 32'h0, ex(0, 0, 1, 1, 8'hAB));
        add(0, 0, 0, 1, 32'hABCDEF01, 32'h0, ex(0, 0, 0, 0, 8'h00));
        // Both requesting from reset with hash-op words (one byte each).
        // Grants alternate AES, SHA, AES, three cycles apart.
        add(1, 0, 0, 1, 32'hA5A5A5A7, 32'h00000013, ex(0, 0, 0, 0, 8'h00));
        add(0, 1, 1, 1, 32'hA5A5A5A7, 32'h00000013, ex(1, 0, 0, 1, 8'h00));
        add(0, 1, 1, 1, 32'hA5A5A5A7, 32'h00000013, ex(0, 0, 1, 1, 8'hA7));
        add(0, 1, 1, 1, 32'hA5A5A5A7, 32'h00000013, ex(0, 0, 0, 0, 8'h00));
        add(0, 1, 1, 1, 32'hA5A5A5A7, 32'h00000013, ex(0, 1, 0, 1, 8'h00));
        add(0, 1, 1, 1, 32'hA5A5A5A7, 32'h00000013, ex(0, 0, 1, 1, 8'h13));
        add(0, 1, 1, 1, 32'hA5A5A5A7, 32'h00000013, ex(0, 0, 0, 0, 8'h00));
        add(0, 1, 1, 1, 32'hA5A5A5A7, 32'h00000013, ex(1, 0, 0, 1, 8'h00));
        add(0, 0, 0, 1, 32'hA5A5A5A7, 32'h00000013, ex(0, 0, 1, 1, 8'hA7));
        add(0, 0, 0, 1, 32'hA5A5A5A7, 32'h00000013, ex(0, 0, 0, 0, 8'h00));

        foreach (vecs[i]) begin
            rst = vecs[i].rst; req_aes = vecs[i].ra; req_sha = vecs[i].rs;
            bus_ready = vecs[i].rdy; data_aes = vecs[i].da; data_sha = vecs[i].ds;
            step();
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Backpressure: byte 1 is held for five stalled cycles, then the
        // transfer resumes with no byte skipped or repeated.
        rst = 1'b1; req_aes = 1'b0; req_sha = 1'b0; bus_ready = 1'b1;
        step();
        rst = 1'b0; req_aes = 1'b1; data_aes = 32'hABCDEF01;
        step();
        check("bp_grant", outs(), ex(1, 0, 0, 1, 8'h00));
        req_aes = 1'b0;
        step();
        check("bp_b0", outs(), ex(0, 0, 1, 1, 8'h01));
        step();
        check("bp_b1", outs(), ex(0, 0, 1, 1, 8'hEF));
        bus_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("bp_hold%0d", k), outs(), ex(0, 0, 1, 1, 8'hEF));
        end
        bus_ready = 1'b1;
        step();
        check("bp_b2", outs(), ex(0, 0, 1, 1, 8'hCD));
        step();
        check("bp_b3", outs(), ex(0, 0, 1, 1, 8'hAB));
        step();
        check("bp_idle", outs(), ex(0, 0, 0, 0, 8'h00));

        // Reset during byte 2: outputs clear on the next cycle, and the next
        // transfer starts again from byte 0.
        req_aes = 1'b1; data_aes = 32'hABCDEF01;
        step();
        req_aes = 1'b0;
        step();
        step();
        step();
        check("rs_b2", outs(), ex(0, 0, 1, 1, 8'hCD));
        rst = 1'b1;
        step();
        check("rs_cleared", outs(), ex(0, 0, 0, 0, 8'h00));
        rst = 1'b0; req_aes = 1'b1; data_aes = 32'h44332210;
        step();
        check("rs_regrant", outs(), ex(1, 0, 0, 1, 8'h00));
        req_aes = 1'b0;
        step();
        check("rs_b0", outs(), ex(0, 0, 1, 1, 8'h10));
        step();
        check("rs_b1", outs(), ex(0, 0, 1, 1, 8'h22));

`ifdef ARB_TIMEOUT_EN
        // Stuck bus: the transfer aborts after 8 stall cycles with an err
        // pulse, and the SHA request that was waiting is granted next.
        rst = 1'b1; bus_ready = 1'b1;
        step();
        rst = 1'b0; req_aes = 1'b1; data_aes = 32'hABCDEF01; bus_ready = 1'b0;
        step();
        check("to_grant", outs(), ex(1, 0, 0, 1, 8'h00));
        req_aes = 1'b0; req_sha = 1'b1; data_sha = 32'h00000013;
        step();
        check("to_send", outs(), ex(0, 0, 1, 1, 8'h01));
        for (int k = 1; k < 8; k++) begin
            step();
            check($sformatf("to_stall%0d", k), outs(), ex(0, 0, 1, 1, 8'h01));
        end
        step();
        check("to_err", outs(), ex(0, 0, 0, 0, 8'h00) | ERR_BIT);
        step();
        check("to_sha_grant", outs(), ex(0, 1, 0, 1, 8'h00));
        req_sha = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Sits directly downstream of the accelerator control FSMs (AES FSM, SHA FSM) and arbitrates their access to the shared 8-bit data bus.
- Each FSM raises a request and holds a command word of {address, opcode byte}.
- On a grant, the arbiter issues a one-cycle grant pulse, latches the selected FSM's command word, and serializes it byte-by-byte onto the bus with a valid/ready handshake.
- Fair round-robin selection between the two requesters.

Parameters:
- ADDRW, 24, address width; must be a multiple of 8.
- NREQ_BITS, 1, width of the last-grant pointer (fixed 2 requesters).
- TIMEOUT, 255, stall-cycle limit; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_aes  in  1  bus request from AES FSM
- data_aes  in  ADDRW+8  AES command word: [ADDRW+7:8] address, [7:0] opcode byte
- grant_aes  out  1  one-cycle grant pulse to AES FSM
- req_sha  in  1  bus request from SHA FSM
- data_sha  in  ADDRW+8  SHA command word, same layout
- grant_sha  out  1  one-cycle grant pulse to SHA FSM
- bus_data  out  8  byte on data bus
- bus_valid  out  1  bus_data valid
- bus_ready  in  1  bus sink accepts the byte this cycle
- busy  out  1  transfer in progress (state != IDLE)
- err  out  1  timeout abort pulse; tied 0 without ARB_TIMEOUT_EN

Behaviour:
- Clocking and reset:
  - Single clock; all state updates on posedge clk.
  - rst is synchronous active-high.
  - Reset values: all outputs 0; state=IDLE; last_grant=SHA, so AES wins the first tie; byte counter 0; command register 0.
- NBYTES = (ADDRW+8)/8, which is 4 at the default.
- States: IDLE, GRANT, SEND.
- IDLE:
  - If any request is high, select the winner:
    - Only one request high: that requester wins.
    - Both high: the requester not equal to last_grant wins.
  - Next state GRANT; the winner is registered.
- GRANT (exactly one cycle):
  - Assert grant_<winner>=1.
  - Latch data_<winner> into cmd_reg this same cycle. The FSM holds its word steady in its wait state, so the word remains valid after grant.
  - Set last_grant=winner; byte_cnt=0.
  - Set len: len=1 if cmd opcode bits [1:0]==2'b11 (hash-op command, no address payload); otherwise len=NBYTES.
  - Next state SEND.
- SEND:
  - bus_valid=1; bus_data=cmd_reg[8*byte_cnt+7 : 8*byte_cnt], i.e. byte 0 is the opcode byte, followed by the address bytes LSB first.
  - On bus_valid && bus_ready: byte_cnt increments.
  - When the accepted byte is number len-1, go to IDLE.
  - With bus_ready low, bus_data and bus_valid hold stable.
- Grant timing:
  - Grant is never asserted in SEND or IDLE; at most one grant is high per cycle.
  - A request arriving during SEND waits; it is evaluated on the first IDLE cycle.
  - Minimum gap between consecutive grants is len+2 cycles.
- A request deasserted while the arbiter is in GRANT does not cancel the transfer; the latched word is still sent.
- busy=1 in GRANT and SEND.
- Reset mid-SEND: returns to IDLE immediately; bus_valid drops in the cycle after rst is sampled; the partial transfer is discarded.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A stall counter increments each SEND cycle with bus_valid && !bus_ready, and clears on every accepted byte.
  - When the counter reaches TIMEOUT: abort to IDLE, pulse err=1 for one cycle, clear the counter, and leave last_grant updated.
- Not defined:
  - No counter exists; err is constant 0; SEND waits indefinitely for bus_ready.

Test Plan:
- AES only: req_aes=1, data_aes=32'hABCDEF01, bus_ready=1 -> grant_aes pulse in the 2nd cycle after the request; bytes 01,EF,CD,AB on consecutive cycles with bus_valid=1; busy drops afterwards.
- Both requesting from reset -> AES granted first, SHA next; with both still requesting, grants alternate AES,SHA,AES.
- SHA hash-op: data_sha=32'h00000013 -> single byte 13 sent, then IDLE; the next grant is possible 3 cycles after the previous one.
- Backpressure: bus_ready=0 for 5 cycles mid-word -> bus_data and bus_valid held; no byte skipped or duplicated.
- rst=1 during byte 2 -> outputs 0 next cycle; the next request restarts from byte 0.
- ARB_TIMEOUT_EN with TIMEOUT=8 and bus_ready stuck 0 -> err pulses after 8 stall cycles, arbiter returns to IDLE, and a pending SHA request is granted next.
